mult_acc: RTL and testbench

//  Accumulates the signed products from the pipelined shift-add multiplier into frame sums
//  (a dot product of `len` products). Sits directly downstream of the multiplier:
//   - product input = the multiplier's signed result;
//   - prod_vld      = the multiplier's result-ready output.
//  The multiplier cannot be stalled, so a 2-entry output buffer absorbs consumer backpressure.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_acc_if.sv | 32 +++
 rtl/acc_fifo2.sv | 60 ++++++
 rtl/mult_acc.sv | 133 +++++++++++++
 tb/tb_mult_acc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate slice.
// Holds the default widths, the saturation bounds at the default accumulator
// width, and the FSM state encoding used by mult_acc.
package mult_pkg;

  localparam int PROD_W_DEF = 34;  // N+M+2 with N=M=16
  localparam int ACC_W_DEF  = 40;
  localparam int LW_DEF     = 8;

  // Clamp bounds at the default accumulator width.
  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/mult_acc_if.sv
// Bus between the multiplier-side producer / sum consumer and mult_acc.
//   clr, len, prod_vld, prod : frame control and product stream (into mult_acc)
//   sum_rdy                  : consumer ready (into mult_acc)
//   sum_vld, sum, sum_sat    : head of the output buffer (out of mult_acc)
//   drop, busy               : status (out of mult_acc)
// master = the side driving products / consuming sums, slave = mult_acc.
interface mult_acc_if #(
  parameter int P     = mult_pkg::PROD_W_DEF,
  parameter int ACC_W = mult_pkg::ACC_W_DEF,
  parameter int LW    = mult_pkg::LW_DEF
);
  logic                    clr;
  logic [LW-1:0]           len;
  logic                    prod_vld;
  logic signed [P-1:0]     prod;
  logic                    sum_vld;
  logic                    sum_rdy;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_sat;
  logic                    drop;
  logic                    busy;

  modport master (
    output clr, len, prod_vld, prod, sum_rdy,
    input  sum_vld, sum, sum_sat, drop, busy
  );

  modport slave (
    input  clr, len, prod_vld, prod, sum_rdy,
    output sum_vld, sum, sum_sat, drop, busy
  );
endinterface

// File: rtl/acc_fifo2.sv
// Two-entry FIFO carrying {sum, sat} frames out of the accumulator.
//   clk, rst        : clock, synchronous active-high reset
//   push_i, din_i   : write side; a push while full is ignored unless a pop
//                     happens in the same cycle
//   full_o          : both entries occupied
//   pop_i, dout_o   : read side; dout_o is the head, forced to 0 when empty
//   empty_o         : no entries
// Entry 0 is always the head, so the head only moves on a pop.
module acc_fifo2 #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  logic [W-1:0] ent0_q, ent1_q;
  logic [1:0]   cnt_q;
  logic         do_pop, do_push;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i & ~empty_o;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : ent0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= din_i;
          else               ent1_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= din_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mult_acc.sv
// Frame accumulator behind the pipelined shift-add multiplier.
// Sums `len` signed products per frame with saturation and queues each
// frame result {sum, sat} into a 2-entry buffer, since the multiplier
// upstream cannot be stalled.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mult_acc_if.slave
//              in : clr, len, prod_vld, prod, sum_rdy
//              out: sum_vld, sum, sum_sat, drop, busy
module mult_acc
  import mult_pkg::*;
#(
  parameter int P     = PROD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LW    = LW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mult_acc_if.slave  bus
);
  localparam int W1 = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    sat_q, sat_d;
  logic                    drop_q, drop_d;

  logic [LW-1:0]           len_eff;
  logic signed [W1-1:0]    prod_x, acc_x, sum_x;
  logic                    clamp;
  logic signed [ACC_W-1:0] s;
  logic                    last;

  logic                    push, push_flag;
  logic                    full, empty, pop;
  logic [ACC_W:0]          fifo_dout;

  // One guard bit over the accumulator: overflow shows up as the top two
  // bits disagreeing, and the guard bit gives the clamp direction.
  assign prod_x  = {{(W1-P){bus.prod[P-1]}}, bus.prod};
  assign acc_x   = (state_q == ST_ACC) ? {acc_q[ACC_W-1], acc_q} : '0;
  assign sum_x   = acc_x + prod_x;
  assign clamp   = sum_x[ACC_W] ^ sum_x[ACC_W-1];
  assign s       = clamp ? (sum_x[ACC_W] ? MIN_V : MAX_V) : sum_x[ACC_W-1:0];

  assign len_eff = (bus.len == '0) ? LW'(1) : bus.len;
  assign last    = ({1'b0, cnt_q} + (LW+1)'(1)) == {1'b0, len_q};

  assign pop     = bus.sum_rdy & ~empty;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sat_d     = sat_q;
    push      = 1'b0;
    push_flag = sat_q | clamp;
    if (bus.clr) begin
      // Abort wins over a product arriving in the same cycle.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (bus.prod_vld) begin
      case (state_q)
        ST_IDLE: begin
          len_d = len_eff;
          if (len_eff == LW'(1)) begin
            push = 1'b1;
          end else begin
            acc_d   = s;
            cnt_d   = LW'(1);
            sat_d   = clamp;
            state_d = ST_ACC;
          end
        end
        default: begin
          if (last) begin
            push    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            acc_d = s;
            cnt_d = cnt_q + LW'(1);
            sat_d = sat_q | clamp;
          end
        end
      endcase
    end
    drop_d = push & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  acc_fifo2 #(.W(ACC_W+1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({s, push_flag}),
    .full_o  (full),
    .pop_i   (bus.sum_rdy),
    .dout_o  (fifo_dout),
    .empty_o (empty)
  );

  assign bus.sum_vld = ~empty;
  assign bus.sum     = fifo_dout[ACC_W:1];
  assign bus.sum_sat = fifo_dout[0];
  assign bus.drop    = drop_q;
  assign bus.busy    = (state_q == ST_ACC);
endmodule

// File: tb/tb_mult_acc.sv
// Directed bench for mult_acc: a table of single-cycle vectors for the
// frame/clear/back-to-back cases, plus hand-written sequences for
// saturation, buffer backpressure and reset.
module tb_mult_acc;
  localparam int P  = 34;
  localparam int AW = 36;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_acc_if #(.P(P), .ACC_W(AW), .LW(LW)) bus ();
  mult_acc #(.P(P), .ACC_W(AW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string                 nm;
    logic                  clr;
    logic [LW-1:0]         len;
    logic                  vld;
    logic signed [P-1:0]   prod;
    logic                  rdy;
    logic                  e_vld;
    logic signed [AW-1:0]  e_sum;
    logic                  e_sat;
    logic                  e_drop;
    logic                  e_busy;
  } vec_t;

  vec_t tbl[$];

  localparam logic signed [P-1:0]  POS32  = 34'sh0_FFFF_FFFF;  //  2^32-1
  localparam logic signed [P-1:0]  NEG32  = 34'sh3_0000_0000;  // -2^32
  localparam logic signed [P-1:0]  POS33  = 34'sh1_FFFF_FFFF;  //  2^33-1
  localparam logic signed [P-1:0]  NEG33  = 34'sh2_0000_0000;  // -2^33
  localparam logic signed [AW-1:0] SMAX   = 36'sh7_FFFF_FFFF;
  localparam logic signed [AW-1:0] SMIN   = 36'sh8_0000_0000;
  localparam logic signed [AW-1:0] STICKY = 36'sh5_FFFF_FFFF;  // clamp then -2^33

  function automatic vec_t mk(string nm, logic c, logic [LW-1:0] l, logic v,
                              logic signed [P-1:0] p, logic r, logic ev,
                              logic signed [AW-1:0] es, logic esat, logic ed, logic eb);
    vec_t t;
    t.nm = nm; t.clr = c; t.len = l; t.vld = v; t.prod = p; t.rdy = r;
    t.e_vld = ev; t.e_sum = es; t.e_sat = esat; t.e_drop = ed; t.e_busy = eb;
    return t;
  endfunction

  task automatic drive(input logic c, input logic [LW-1:0] l, input logic v,
                       input logic signed [P-1:0] p, input logic r);
    bus.clr = c; bus.len = l; bus.prod_vld = v; bus.prod = p; bus.sum_rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic ev, input logic signed [AW-1:0] es,
                            input logic esat, input logic ed, input logic eb);
    logic [AW+3:0] act, exp;
    act = {bus.sum_vld, bus.sum, bus.sum_sat, bus.drop, bus.busy};
    exp = {ev, es, esat, ed, eb};
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got vld=%0b sum=%0d sat=%0b drop=%0b busy=%0b, want vld=%0b sum=%0d sat=%0b drop=%0b busy=%0b",
               nm, bus.sum_vld, bus.sum, bus.sum_sat, bus.drop, bus.busy, ev, es, esat, ed, eb);
    end
  endtask

  initial begin
    // frame of 3: 5-2+7
    tbl.push_back(mk("t1_p0", 0, 3, 1, 5,  1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("t1_p1", 0, 3, 1, -2, 1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("t1_p2", 0, 3, 1, 7,  1, 1, 10, 0, 0, 0));
    tbl.push_back(mk("t1_pop",0, 3, 0, 0,  1, 0, 0,  0, 0, 0));
    // partial frame aborted by clr, then a clean frame of four 1s
    tbl.push_back(mk("t4_a0", 0, 4, 1, 100, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t4_a1", 0, 4, 1, 100, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t4_clr",1, 4, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t4_b0", 0, 4, 1, 1,   1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t4_b1", 0, 4, 1, 1,   1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t4_b2", 0, 4, 1, 1,   1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t4_b3", 0, 4, 1, 1,   1, 1, 4, 0, 0, 0));
    tbl.push_back(mk("t4_pop",0, 4, 0, 0,   1, 0, 0, 0, 0, 0));
    // clr together with a product: product discarded
    tbl.push_back(mk("clr_wins", 1, 1, 1, 50, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("clr_none", 0, 1, 0, 0,  1, 0, 0, 0, 0, 0));
    // len=2 back-to-back frames 1..6
    tbl.push_back(mk("t5_1", 0, 2, 1, 1, 1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("t5_2", 0, 2, 1, 2, 1, 1, 3,  0, 0, 0));
    tbl.push_back(mk("t5_3", 0, 2, 1, 3, 1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("t5_4", 0, 2, 1, 4, 1, 1, 7,  0, 0, 0));
    tbl.push_back(mk("t5_5", 0, 2, 1, 5, 1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("t5_6", 0, 2, 1, 6, 1, 1, 11, 0, 0, 0));
    tbl.push_back(mk("t5_end",0, 2, 0, 0, 1, 0, 0,  0, 0, 0));
    // len change mid-frame is ignored
    tbl.push_back(mk("len_a", 0, 2, 1, 20, 1, 0, 0,  0, 0, 1));
    tbl.push_back(mk("len_b", 0, 7, 1, 22, 1, 1, 42, 0, 0, 0));
    tbl.push_back(mk("len_c", 0, 7, 0, 0,  1, 0, 0,  0, 0, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].len, tbl[i].vld, tbl[i].prod, tbl[i].rdy);
      tick();
      expect_out(tbl[i].nm, tbl[i].e_vld, tbl[i].e_sum, tbl[i].e_sat, tbl[i].e_drop, tbl[i].e_busy);
    end

    // positive saturation on the 9th product
    drive(0, 9, 1, POS32, 1);
    for (int i = 0; i < 8; i++) tick();
    expect_out("t2_pos_mid", 0, 0, 0, 0, 1);
    tick();
    expect_out("t2_pos_sum", 1, SMAX, 1, 0, 0);
    drive(0, 9, 0, 0, 1);
    tick();
    expect_out("t2_pos_pop", 0, 0, 0, 0, 0);

    // negative saturation
    drive(0, 9, 1, NEG32, 1);
    for (int i = 0; i < 9; i++) tick();
    expect_out("t2_neg_sum", 1, SMIN, 1, 0, 0);
    drive(0, 9, 0, 0, 1);
    tick();

    // sat flag does not leak into the next frame
    drive(0, 1, 1, 3, 1);
    tick();
    expect_out("sat_clear", 1, 3, 0, 0, 0);

    // sticky sat: clamp on 5th product, then back inside range
    drive(0, 6, 1, POS33, 1);
    for (int i = 0; i < 5; i++) tick();
    drive(0, 6, 1, NEG33, 1);
    tick();
    expect_out("sat_sticky", 1, STICKY, 1, 0, 0);
    drive(0, 6, 0, 0, 1);
    tick();
    expect_out("sticky_pop", 0, 0, 0, 0, 0);

    // backpressure: third frame dropped while full
    drive(0, 1, 1, 1, 0);
    tick();
    expect_out("t3_f1", 1, 1, 0, 0, 0);
    drive(0, 1, 1, 2, 0);
    tick();
    expect_out("t3_f2", 1, 1, 0, 0, 0);
    drive(0, 1, 1, 3, 0);
    tick();
    expect_out("t3_drop", 1, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 1);
    tick();
    expect_out("t3_pop2", 1, 2, 0, 0, 0);
    tick();
    expect_out("t3_empty", 0, 0, 0, 0, 0);

    // push and pop together while full
    drive(0, 1, 1, 4, 0);
    tick();
    drive(0, 1, 1, 5, 0);
    tick();
    expect_out("pp_full", 1, 4, 0, 0, 0);
    drive(0, 1, 1, 6, 1);
    tick();
    expect_out("pp_swap", 1, 5, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    tick();
    expect_out("pp_last", 1, 6, 0, 0, 0);
    tick();
    expect_out("pp_empty", 0, 0, 0, 0, 0);

    // reset with one buffered sum and a frame half done
    drive(0, 1, 1, 8, 0);
    tick();
    expect_out("t6_buf", 1, 8, 0, 0, 0);
    drive(0, 4, 1, 1, 0);
    tick();
    tick();
    expect_out("t6_half", 1, 8, 0, 0, 1);
    rst = 1'b1;
    drive(0, 4, 0, 0, 0);
    tick();
    expect_out("t6_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1, 9, 1);
    tick();
    expect_out("t6_len0", 1, 9, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    tick();
    expect_out("t6_end", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
